ap_mem_responder: RTL

//  Memory-side responder for an HLS ap_memory single-port array interface (address0/ce0/we0/d0/q0).

---
 rtl/ap_mem_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ap_mem_responder.sv
// Memory-side responder for an HLS ap_memory single-port array: serves reads from a
// host-preloaded buffer with 1-cycle latency and captures write-backs into a window.
module ap_mem_responder #(
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int DW      = 8,
    parameter int WIN_LEN = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  host_we,
    input  logic [AW-1:0]         host_addr,
    input  logic [DW-1:0]         host_wdata,
    output logic [DW-1:0]         host_rdata,
    input  logic                  start,
    input  logic                  clear,
    input  logic [AW-1:0]         cap_base,
    input  logic [AW-1:0]         data_address0,
    input  logic                  data_ce0,
    input  logic                  data_we0,
    input  logic [DW-1:0]         data_d0,
    output logic [DW-1:0]         data_q0,
    output logic                  armed,
    output logic                  cap_vld,
    output logic [WIN_LEN*DW-1:0] cap_data,
    output logic [AW:0]           rd_cnt,
    output logic [AW:0]           wr_cnt,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    // Accelerator port: an access is presented when data_ce0 is high in a cycle and is
    // taken on that rising edge; there is no back-pressure, so every ce0 is consumed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [AW:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic [DW-1:0]         data_q0_q, data_q0_d;
    logic [WIN_LEN*DW-1:0] cap_data_q, cap_data_d;
    logic [WIN_LEN-1:0]    flag_q, flag_d;
    logic [AW:0]           rd_cnt_q, rd_cnt_d;
    logic [AW:0]           wr_cnt_q, wr_cnt_d;
    logic                  err_q, err_d;
    logic [AW-1:0]         cap_base_q, cap_base_d;

    logic [DW-1:0]         mem_q [DEPTH];
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DW-1:0]         mem_wdata;

    logic                  acc_rd, acc_wr, addr_ok, host_ok, serve, start_go, in_win;
    logic [AW:0]           win_end;
    logic [AW-1:0]         off;

    always_comb begin
        acc_rd   = data_ce0 & ~data_we0;
        acc_wr   = data_ce0 & data_we0;
        addr_ok  = (32'(data_address0) < DEPTH);
        host_ok  = (32'(host_addr) < DEPTH);
        serve    = (state_q == ST_ARMED) || (state_q == ST_DONE);
        start_go = (state_q == ST_IDLE) && start && !clear;
        // Window end in AW+1 bits so a base near the top never wraps to address 0.
        win_end  = {1'b0, cap_base_q} + (AW + 1)'(WIN_LEN);
        in_win   = (data_address0 >= cap_base_q) && ({1'b0, data_address0} < win_end);
        off      = data_address0 - cap_base_q;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = host_addr;
        mem_wdata = host_wdata;
        if (state_q == ST_IDLE) begin
            mem_we = host_we && host_ok;
        end else if (serve && acc_wr && addr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = data_address0;
            mem_wdata = data_d0;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_q0_d  = data_q0_q;
        cap_data_d = cap_data_q;
        flag_d     = flag_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        cap_base_d = cap_base_q;

        if (serve && acc_rd) begin
            data_q0_d = addr_ok ? mem_q[data_address0] : '0;
        end
        if ((state_q == ST_IDLE && data_ce0) || (serve && data_ce0 && !addr_ok)) begin
            err_d = 1'b1;
        end

        if (state_q == ST_ARMED) begin
            if (acc_rd && rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 1'b1;
            if (acc_wr && wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
            if (acc_wr && addr_ok && in_win) begin
                for (int k = 0; k < WIN_LEN; k++) begin
                    if (off == AW'(k) && !flag_q[k]) begin
                        cap_data_d[k*DW +: DW] = data_d0;
                        flag_d[k]              = 1'b1;
                    end
                end
            end
            if (&flag_d) state_d = ST_DONE;
        end

        if (start_go) begin
            state_d    = ST_ARMED;
            cap_base_d = cap_base;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            err_d      = 1'b0;
            cap_data_d = '0;
            flag_d     = '0;
        end
        if (clear) begin
            state_d    = ST_IDLE;
            cap_data_d = '0;
            flag_d     = '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_IDLE;
            data_q0_q  <= '0;
            cap_data_q <= '0;
            flag_q     <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            err_q      <= 1'b0;
            cap_base_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q0_q  <= data_q0_d;
            cap_data_q <= cap_data_d;
            flag_q     <= flag_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
            cap_base_q <= cap_base_d;
        end
    end

    // The buffer survives reset so host-preloaded contents outlive an aborted run.
    always_ff @(posedge ap_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign host_rdata = host_ok ? mem_q[host_addr] : '0;
    assign data_q0    = data_q0_q;
    assign armed      = (state_q == ST_ARMED);
    assign cap_vld    = (state_q == ST_DONE);
    assign cap_data   = cap_data_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule
